// File: rtl/pwm_bridge_ctrl.sv
// PWM bridge controller: period/duty generator with shadowed configuration and stop sequencing.
// Build option PWM_FAULT_LATCH_EN adds Fault/FaultClr, a 2-flop fault synchronizer and the FAULT state.
module pwm_bridge_ctrl #(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                 MClk,
    input  logic                 RstN,
    input  logic                 Enable,
    input  logic [BIT_WIDTH-1:0] PeriodIn,
    input  logic [BIT_WIDTH-1:0] DutyIn,
    input  logic [BIT_WIDTH-1:0] DeadTimeIn,
    input  logic                 LoadReq,
`ifdef PWM_FAULT_LATCH_EN
    input  logic                 Fault,
    input  logic                 FaultClr,
`endif
    output logic                 LoadAck,
    output logic [1:0]           SPDT,
    output logic [BIT_WIDTH-1:0] DeadTimeCount,
    output logic [BIT_WIDTH-1:0] PeriodCount,
    output logic                 PeriodEnd,
    output logic [1:0]           State
);

    localparam int unsigned SpdtW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STOP  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    state_e                 r_state;
    logic [BIT_WIDTH-1:0]   r_cnt;
    logic [BIT_WIDTH-1:0]   r_act_period;
    logic [BIT_WIDTH-1:0]   r_act_duty;
    logic [BIT_WIDTH-1:0]   r_act_dead;
    logic                   r_pending;
    logic                   r_idle_ack;
    logic [SpdtW-1:0]       r_spdt;

    state_e                 w_state_nxt;
    logic [BIT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_pending_nxt;
    logic                   w_idle_ack_nxt;
    logic [SpdtW-1:0]       w_spdt_nxt;
    logic                   w_load;
    logic                   w_running;
    logic                   w_period_end;
    logic                   w_boundary;
    logic                   w_load_end;
    logic                   w_fault;

`ifdef PWM_FAULT_LATCH_EN
    logic r_fault_meta;
    logic r_fault_sync;

    // Two-flop synchronizer for the asynchronous fault input
    always_ff @(posedge MClk) begin
        if (!RstN) begin
            r_fault_meta <= 1'b0;
            r_fault_sync <= 1'b0;
        end else begin
            r_fault_meta <= Fault;
            r_fault_sync <= r_fault_meta;
        end
    end

    assign w_fault = r_fault_sync;
`else
    assign w_fault = 1'b0;
`endif

    // A zero period has no last count, so every cycle is treated as a boundary for loads and stop
    assign w_running    = (r_state == ST_RUN) || (r_state == ST_STOP);
    assign w_period_end = w_running && (r_act_period != '0) &&
                          (r_cnt == r_act_period - BIT_WIDTH'(1));
    assign w_boundary   = w_running && (w_period_end || (r_act_period == '0));
    assign w_load_end   = w_boundary && (r_pending || LoadReq) && !w_fault;

    always_ff @(posedge MClk) begin
        if (!RstN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_act_period <= '0;
            r_act_duty   <= '0;
            r_act_dead   <= '0;
            r_pending    <= 1'b0;
            r_idle_ack   <= 1'b0;
            r_spdt       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_idle_ack <= w_idle_ack_nxt;
            r_spdt     <= w_spdt_nxt;
            if (w_load) begin
                r_act_period <= PeriodIn;
                r_act_duty   <= DutyIn;
                r_act_dead   <= DeadTimeIn;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_pending_nxt  = r_pending;
        w_idle_ack_nxt = 1'b0;
        w_spdt_nxt     = '0;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_pending_nxt = 1'b0;
                if (LoadReq) begin
                    w_load         = 1'b1;
                    w_idle_ack_nxt = 1'b1;
                end
                if (Enable) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_STOP: begin
                w_cnt_nxt = w_boundary ? '0 : r_cnt + BIT_WIDTH'(1);
                if (w_load_end) begin
                    w_load        = 1'b1;
                    w_pending_nxt = 1'b0;
                end else if (LoadReq) begin
                    w_pending_nxt = 1'b1;
                end
                // STOP finishes the period, but re-enable resumes without touching the count
                if (r_state == ST_RUN) begin
                    if (!Enable) w_state_nxt = ST_STOP;
                end else if (w_boundary) begin
                    w_state_nxt = Enable ? ST_RUN : ST_IDLE;
                end else if (Enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
`ifdef PWM_FAULT_LATCH_EN
            ST_FAULT: begin
                w_pending_nxt = 1'b0;
                if (FaultClr && !w_fault) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_fault) begin
            w_state_nxt    = ST_FAULT;
            w_cnt_nxt      = '0;
            w_pending_nxt  = 1'b0;
            w_idle_ack_nxt = 1'b0;
            w_load         = 1'b0;
        end

        // Drive decision lags the count by one cycle; idle/fault next cycle forces both sides off
        if (w_running && (r_act_period != '0) &&
            ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_STOP))) begin
            w_spdt_nxt = (r_cnt < r_act_duty) ? 2'b10 : 2'b01;
        end
    end

    assign State         = r_state;
    assign SPDT          = r_spdt;
    assign PeriodCount   = r_cnt;
    assign DeadTimeCount = r_act_dead;
    assign PeriodEnd     = w_period_end;
    assign LoadAck       = w_load_end | r_idle_ack;

endmodule
